// File: rtl/processor_control_unit.sv
// +----------------------------------------------------------------------------+
// | processor_control_unit: per-processor index responder computing C[i][j].   |
// | Optional PCU_SATURATE_EN saturates the written result to signed DATA_W.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module processor_control_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Indexes_Ready,
  input  logic [IDX_W-1:0]  i_Row_Index,
  input  logic [IDX_W-1:0]  i_Column_Index,
  output logic              o_Indexes_Received,
  input  logic [ADDR_W-1:0] i_Base_A,
  input  logic [ADDR_W-1:0] i_Base_B,
  input  logic [ADDR_W-1:0] i_Base_C,
  input  logic [IDX_W-1:0]  i_K,
  input  logic [IDX_W-1:0]  i_M,
  output logic              o_Grant_Request,
  input  logic              i_Grant,
  output logic [ADDR_W-1:0] o_Memory_Address,
  output logic              o_Memory_Read,
  output logic              o_Memory_Write,
  output logic [DATA_W-1:0] o_Memory_Write_Data,
  input  logic [DATA_W-1:0] i_Memory_Read_Data,
  output logic              o_Result_Ready,
  output logic              o_Busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_MAC   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]           kdim_q, kdim_d, mdim_q, mdim_d;
  logic [IDX_W-1:0]           k_q, k_d;
  logic [ADDR_W-1:0]          base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic signed [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]          a_q, a_d;
  logic                       a_pend_q, a_pend_d;
  logic                       received_q, received_d;

  logic [ADDR_W-1:0]          addr_a, addr_b, addr_c;
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [IDX_W:0]             k_inc;
  logic [DATA_W-1:0]          result;

  assign addr_a = base_a_q + ADDR_W'(ADDR_W'(row_q) * ADDR_W'(kdim_q)) + ADDR_W'(k_q);
  assign addr_b = base_b_q + ADDR_W'(ADDR_W'(k_q) * ADDR_W'(mdim_q)) + ADDR_W'(col_q);
  assign addr_c = base_c_q + ADDR_W'(ADDR_W'(row_q) * ADDR_W'(mdim_q)) + ADDR_W'(col_q);

  assign a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
  assign b_ext = {{DATA_W{i_Memory_Read_Data[DATA_W-1]}}, i_Memory_Read_Data};
  assign prod  = a_ext * b_ext;
  assign k_inc = {1'b0, k_q} + {{IDX_W{1'b0}}, 1'b1};

`ifdef PCU_SATURATE_EN
  localparam logic signed [2*DATA_W-1:0] c_sat_max = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] c_sat_min = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    result = acc_q[DATA_W-1:0];
    if (acc_q > c_sat_max) begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (acc_q < c_sat_min) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end
`else
  assign result = acc_q[DATA_W-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    kdim_d     = kdim_q;
    mdim_d     = mdim_q;
    k_d        = k_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    base_c_d   = base_c_q;
    acc_d      = acc_q;
    a_d        = a_q;
    a_pend_d   = 1'b0;
    received_d = 1'b0;

    o_Grant_Request     = 1'b0;
    o_Memory_Address    = '0;
    o_Memory_Read       = 1'b0;
    o_Memory_Write      = 1'b0;
    o_Memory_Write_Data = '0;
    o_Result_Ready      = 1'b0;

    // A data returns the cycle after its read, even if RD_B is then stalled
    if (a_pend_q) begin
      a_d = i_Memory_Read_Data;
    end

    case (state_q)
      S_IDLE: begin
        if (i_Indexes_Ready) begin
          row_d      = i_Row_Index;
          col_d      = i_Column_Index;
          kdim_d     = i_K;
          mdim_d     = i_M;
          base_a_d   = i_Base_A;
          base_b_d   = i_Base_B;
          base_c_d   = i_Base_C;
          acc_d      = '0;
          k_d        = '0;
          received_d = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        o_Grant_Request = 1'b1;
        if (i_Grant) begin
          state_d = (kdim_q != '0) ? S_RD_A : S_WRITE;
        end
      end
      S_RD_A: begin
        o_Grant_Request  = 1'b1;
        o_Memory_Address = addr_a;
        if (i_Grant) begin
          o_Memory_Read = 1'b1;
          a_pend_d      = 1'b1;
          state_d       = S_RD_B;
        end
      end
      S_RD_B: begin
        o_Grant_Request  = 1'b1;
        o_Memory_Address = addr_b;
        if (i_Grant) begin
          o_Memory_Read = 1'b1;
          state_d       = S_MAC;
        end
      end
      S_MAC: begin
        o_Grant_Request = 1'b1;
        acc_d           = acc_q + prod;
        k_d             = k_inc[IDX_W-1:0];
        state_d         = (k_inc < {1'b0, kdim_q}) ? S_RD_A : S_WRITE;
      end
      S_WRITE: begin
        o_Grant_Request     = 1'b1;
        o_Memory_Address    = addr_c;
        o_Memory_Write_Data = result;
        if (i_Grant) begin
          o_Memory_Write = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        o_Result_Ready = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_Busy             = (state_q != S_IDLE);
  assign o_Indexes_Received = received_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      kdim_q     <= '0;
      mdim_q     <= '0;
      k_q        <= '0;
      base_a_q   <= '0;
      base_b_q   <= '0;
      base_c_q   <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      a_pend_q   <= 1'b0;
      received_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      kdim_q     <= kdim_d;
      mdim_q     <= mdim_d;
      k_q        <= k_d;
      base_a_q   <= base_a_d;
      base_b_q   <= base_b_d;
      base_c_q   <= base_c_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      a_pend_q   <= a_pend_d;
      received_q <= received_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_processor_control_unit.sv
// +----------------------------------------------------------------------------+
// | tb_processor_control_unit: directed bench for processor_control_unit.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_processor_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        idx_rdy;
  logic [7:0]  row, col, kdim, mdim;
  logic [15:0] base_a, base_b, base_c;
  logic        grant;
  logic        received, req, rd, wr, res_rdy, busy;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata = 32'd0;

  // Narrow instance for the overflow case
  logic        rdy8;
  logic        received8, req8, rd8, wr8, res_rdy8, busy8;
  logic [15:0] addr8;
  logic [7:0]  wdata8;
  logic [7:0]  rdata8 = 8'd0;

  logic [31:0] mem [0:1023];
  logic [15:0] rd_log [0:15];
  int          rd_n, wr_n, overlap, bad_strobe, rx_extra;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  int          passed, total, lat;

  always #5 clk = ~clk;

  processor_control_unit #(.DATA_W(32), .ADDR_W(16), .IDX_W(8)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Indexes_Ready(idx_rdy),
    .i_Row_Index(row), .i_Column_Index(col), .o_Indexes_Received(received),
    .i_Base_A(base_a), .i_Base_B(base_b), .i_Base_C(base_c),
    .i_K(kdim), .i_M(mdim), .o_Grant_Request(req), .i_Grant(grant),
    .o_Memory_Address(addr), .o_Memory_Read(rd), .o_Memory_Write(wr),
    .o_Memory_Write_Data(wdata), .i_Memory_Read_Data(rdata),
    .o_Result_Ready(res_rdy), .o_Busy(busy)
  );

  processor_control_unit #(.DATA_W(8), .ADDR_W(16), .IDX_W(8)) dut8 (
    .i_Clock(clk), .i_Reset(rst), .i_Indexes_Ready(rdy8),
    .i_Row_Index(8'd0), .i_Column_Index(8'd0), .o_Indexes_Received(received8),
    .i_Base_A(16'd0), .i_Base_B(16'd4), .i_Base_C(16'd8),
    .i_K(8'd2), .i_M(8'd1), .o_Grant_Request(req8), .i_Grant(1'b1),
    .o_Memory_Address(addr8), .o_Memory_Read(rd8), .o_Memory_Write(wr8),
    .o_Memory_Write_Data(wdata8), .i_Memory_Read_Data(rdata8),
    .o_Result_Ready(res_rdy8), .o_Busy(busy8)
  );

  // Memory: read data is valid the cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    if (rd) begin
      rdata <= mem[addr[9:0]];
      if (rd_n < 16) rd_log[rd_n] = addr;
      rd_n++;
    end else begin
      rdata <= 32'hDEAD_BEEF;
    end
    if (wr) begin
      wr_n++;
      wr_addr = addr;
      wr_data = wdata;
    end
    if (rd && wr) overlap++;
    if (!grant && (rd || wr)) bad_strobe++;
    rdata8 <= (rd8 && addr8 < 16'd6) ? 8'd100 : 8'd0;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic start_job(input logic [7:0] ri, input logic [7:0] rj,
                           input logic [7:0] rk, input logic [7:0] rm);
    rd_n    = 0;
    wr_n    = 0;
    row     = ri;
    col     = rj;
    kdim    = rk;
    mdim    = rm;
    idx_rdy = 1'b1;
    @(posedge clk); #1;
    idx_rdy = 1'b0;
    chk("received_pulse", received, 1);
    chk("busy_after_accept", busy, 1);
    chk("req_in_REQ", req, 1);
  endtask

  // lat counts cycles after the accept edge; current sample is cycle 1
  task automatic wait_done(input int stall_at, input int stall_len, input int handoff_at,
                           input logic [15:0] stall_addr, output int l);
    l = 1;
    while (!res_rdy && l < 100) begin
      if (l == stall_at) grant = 1'b0;
      if (l == stall_at + stall_len) grant = 1'b1;
      if (l == handoff_at) begin
        idx_rdy = 1'b1;
        row     = 8'd0;
        col     = 8'd0;
      end
      @(posedge clk); #1;
      l++;
      if (received) rx_extra++;
      if (stall_len > 0 && l == stall_at + 2) begin
        chk("stall_read_low", rd, 0);
        chk("stall_addr_frozen", addr, stall_addr);
        chk("stall_req_high", req, 1);
      end
    end
    chk("result_ready_seen", res_rdy, 1);
  endtask

  initial begin
    int n;
    passed = 0; total = 0; rd_n = 0; wr_n = 0;
    overlap = 0; bad_strobe = 0; rx_extra = 0;
    rst = 1'b1; idx_rdy = 1'b0; rdy8 = 1'b0; grant = 1'b1;
    row = 8'd0; col = 8'd0; kdim = 8'd0; mdim = 8'd0;
    base_a = 16'h0100; base_b = 16'h0200; base_c = 16'h0300;
    for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
    mem[10'h102] = 32'd3;
    mem[10'h103] = 32'hFFFF_FFFC;
    mem[10'h202] = 32'd5;
    mem[10'h205] = 32'd6;
    mem[10'h100] = 32'd2;
    mem[10'h101] = 32'd7;
    mem[10'h200] = 32'hFFFF_FFFD;
    mem[10'h203] = 32'd4;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", req, 0);
    chk("rst_read", rd, 0);
    chk("rst_write", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ready", res_rdy, 0);
    chk("rst_received", received, 0);
    rst = 1'b0;

    // Basic dot product: 3*5 + (-4)*6 = -9
    start_job(8'd1, 8'd2, 8'd2, 8'd3);
    wait_done(-1, 0, -1, 16'd0, lat);
    chk("basic_latency", lat, 9);
    chk("basic_read_count", rd_n, 4);
    chk("basic_rd0", rd_log[0], 16'h0102);
    chk("basic_rd1", rd_log[1], 16'h0202);
    chk("basic_rd2", rd_log[2], 16'h0103);
    chk("basic_rd3", rd_log[3], 16'h0205);
    chk("basic_write_count", wr_n, 1);
    chk("basic_write_addr", wr_addr, 16'h0305);
    chk("basic_write_data", wr_data, 32'hFFFF_FFF7);
    @(posedge clk); #1;
    chk("basic_idle_busy", busy, 0);
    chk("basic_ready_pulse", res_rdy, 0);

    // Grant dropped for 4 cycles while in RD_B of k=0
    start_job(8'd1, 8'd2, 8'd2, 8'd3);
    wait_done(3, 4, -1, 16'h0202, lat);
    chk("stall_latency", lat, 13);
    chk("stall_read_count", rd_n, 4);
    chk("stall_rd1", rd_log[1], 16'h0202);
    chk("stall_write_data", wr_data, 32'hFFFF_FFF7);
    @(posedge clk); #1;

    // Handoff raised during MAC and held until accepted after DONE
    rx_extra = 0;
    start_job(8'd1, 8'd2, 8'd2, 8'd3);
    wait_done(-1, 0, 4, 16'd0, lat);
    chk("handoff_no_pulse_busy", rx_extra, 0);
    chk("handoff_first_latency", lat, 9);
    chk("handoff_first_addr", wr_addr, 16'h0305);
    chk("handoff_first_data", wr_data, 32'hFFFF_FFF7);
    @(posedge clk); #1;
    chk("handoff_idle_busy", busy, 0);
    chk("handoff_idle_no_pulse", received, 0);
    @(posedge clk); #1;
    chk("handoff_received", received, 1);
    chk("handoff_busy", busy, 1);
    idx_rdy = 1'b0;
    rd_n = 0;
    wr_n = 0;
    wait_done(-1, 0, -1, 16'd0, lat);
    chk("handoff_second_latency", lat, 9);
    chk("handoff_second_addr", wr_addr, 16'h0300);
    chk("handoff_second_data", wr_data, 32'd22);
    @(posedge clk); #1;

    // Reset while in RD_A of k=1
    start_job(8'd1, 8'd2, 8'd2, 8'd3);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_read", rd, 1);
    chk("pre_reset_addr", addr, 16'h0103);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_req", req, 0);
    chk("midrst_read", rd, 0);
    chk("midrst_write", wr, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_ready", res_rdy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_write", wr_n, 0);

    // K=0: single write of zero, no reads
    start_job(8'd3, 8'd1, 8'd0, 8'd4);
    wait_done(-1, 0, -1, 16'd0, lat);
    chk("k0_latency", lat, 3);
    chk("k0_read_count", rd_n, 0);
    chk("k0_write_count", wr_n, 1);
    chk("k0_write_addr", wr_addr, 16'h030D);
    chk("k0_write_data", wr_data, 32'd0);
    @(posedge clk); #1;

    // Overflow on the 8-bit instance: 100*100 + 100*100 = 20000
    rdy8 = 1'b1;
    @(posedge clk); #1;
    rdy8 = 1'b0;
    n = 0;
    while (!wr8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ovf_write_seen", wr8, 1);
    chk("ovf_write_addr", addr8, 16'd8);
`ifdef PCU_SATURATE_EN
    chk("ovf_write_data", wdata8, 8'h7F);
`else
    chk("ovf_write_data", wdata8, 8'h20);
`endif

    chk("strobe_overlap", overlap, 0);
    chk("strobe_without_grant", bad_strobe, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
